// File: rtl/project_pwm_pkg.sv
// Shared encodings for the PWM timebase array: counter modes and sync-out sources.
package project_pwm_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_UPDOWN = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  localparam logic [1:0] SYNC_ZERO = 2'b00;
  localparam logic [1:0] SYNC_PRD  = 2'b01;
  localparam logic [1:0] SYNC_CMP  = 2'b10;
  localparam logic [1:0] SYNC_OFF  = 2'b11;

endpackage

// File: rtl/project_pwm_timebase_channel.sv
// One PWM timebase channel: counter, direction, period (optionally shadowed) and sync-out.
// Define PROJECT_PWM_SHADOW_EN to double-buffer the period register.
module project_pwm_timebase_channel
  import project_pwm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_period_wr,
  input  logic [WIDTH-1:0] i_phase,
  input  logic             i_phase_en,
  input  logic             i_phase_dir,
  input  logic [1:0]       i_sync_sel,
  input  logic [WIDTH-1:0] i_sync_cmp,
  input  logic             i_sync_in,
  output logic [WIDTH-1:0] o_counter,
  output logic [WIDTH-1:0] o_counter_next,
  output logic             o_dir,
  output logic             o_zero,
  output logic             o_prd,
  output logic             o_sync
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             sync_q, sync_d;
  logic             frozen_q, frozen_d;
  logic             hold;
  logic             phase_load;
  logic             reload;
  logic             event_hit;

  always_comb begin
    counter_d  = counter_q;
    dir_d      = dir_q;
    reload     = 1'b0;
    hold       = !i_en || (i_mode == MODE_FREEZE);
    phase_load = !hold && i_sync_in && i_phase_en;
    if (hold) begin
      counter_d = counter_q;
    end else if (phase_load) begin
      counter_d = (i_phase > period_q) ? period_q : i_phase;
      dir_d     = (i_mode == MODE_UPDOWN) ? i_phase_dir : (i_mode == MODE_DOWN);
    end else begin
      case (i_mode)
        MODE_UP: begin
          dir_d = 1'b0;
          if (counter_q >= period_q) begin
            counter_d = '0;
            reload    = 1'b1;
          end else begin
            counter_d = counter_q + ONE;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b1;
          if ((counter_q == '0) || (counter_q > period_q)) begin
            counter_d = period_q;
            reload    = 1'b1;
          end else begin
            counter_d = counter_q - ONE;
          end
        end
        default: begin
          // Up-down: turn around at P and at 0; an over-range count snaps back to P.
          if (!dir_q) begin
            if (counter_q >= period_q) begin
              counter_d = (period_q == '0) ? '0 : period_q - ONE;
              dir_d     = 1'b1;
            end else begin
              counter_d = counter_q + ONE;
            end
          end else if (counter_q == '0) begin
            counter_d = (period_q == '0) ? '0 : ONE;
            dir_d     = 1'b0;
          end else if (counter_q > period_q) begin
            counter_d = period_q;
          end else begin
            counter_d = counter_q - ONE;
          end
          reload = (counter_d == '0);
        end
      endcase
    end
  end

  always_comb begin
    case (i_sync_sel)
      SYNC_ZERO: event_hit = (counter_d == '0);
      SYNC_PRD:  event_hit = (counter_d == period_q);
      SYNC_CMP:  event_hit = (counter_d == i_sync_cmp);
      default:   event_hit = 1'b0;
    endcase
  end

  // A frozen counter sitting on the event value pulses only on its first frozen cycle.
  assign frozen_d = i_en && (i_mode == MODE_FREEZE);
  assign sync_d   = i_en && event_hit && !(frozen_d && frozen_q);

`ifdef PROJECT_PWM_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = i_period_wr ? i_period : shadow_q;
    period_d = period_q;
    if (i_period_wr && (!i_en || reload)) begin
      period_d = i_period;
    end else if (reload) begin
      period_d = shadow_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  assign period_d = i_period_wr ? i_period : period_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      counter_q <= '0;
      period_q  <= '0;
      dir_q     <= 1'b0;
      sync_q    <= 1'b0;
      frozen_q  <= 1'b0;
    end else begin
      counter_q <= counter_d;
      period_q  <= period_d;
      dir_q     <= dir_d;
      sync_q    <= sync_d;
      frozen_q  <= frozen_d;
    end
  end

  assign o_counter      = counter_q;
  assign o_counter_next = counter_d;
  assign o_dir          = dir_q;
  assign o_zero         = (counter_q == '0);
  assign o_prd          = (counter_q == period_q);
  assign o_sync         = sync_q;

endmodule

// File: rtl/project_pwm_timebase_array.sv
// Bank of PWM timebase channels with a daisy-chained sync path ch0 -> ch1 -> ... -> chN-1.
// Define PROJECT_PWM_SHADOW_EN to double-buffer every channel's period register.
module project_pwm_timebase_array
  import project_pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [CHANNELS-1:0]       i_en,
  input  logic [2*CHANNELS-1:0]     i_mode,
  input  logic [WIDTH*CHANNELS-1:0] i_period,
  input  logic [CHANNELS-1:0]       i_period_wr,
  input  logic [WIDTH*CHANNELS-1:0] i_phase,
  input  logic [CHANNELS-1:0]       i_phase_en,
  input  logic [CHANNELS-1:0]       i_phase_dir,
  input  logic [2*CHANNELS-1:0]     i_sync_sel,
  input  logic [WIDTH*CHANNELS-1:0] i_sync_cmp,
  input  logic                      i_ext_sync,
  output logic [WIDTH*CHANNELS-1:0] o_counter,
  output logic [WIDTH*CHANNELS-1:0] o_counter_next,
  output logic [CHANNELS-1:0]       o_dir,
  output logic [CHANNELS-1:0]       o_zero,
  output logic [CHANNELS-1:0]       o_prd,
  output logic [CHANNELS-1:0]       o_sync
);

  logic [CHANNELS-1:0] sync_in;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      if (gi == 0) begin : g_head
        assign sync_in[gi] = i_ext_sync;
      end else begin : g_link
        assign sync_in[gi] = o_sync[gi-1];
      end

      project_pwm_timebase_channel #(
        .WIDTH(WIDTH)
      ) u_channel (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en[gi]),
        .i_mode        (i_mode[2*gi +: 2]),
        .i_period      (i_period[gi*WIDTH +: WIDTH]),
        .i_period_wr   (i_period_wr[gi]),
        .i_phase       (i_phase[gi*WIDTH +: WIDTH]),
        .i_phase_en    (i_phase_en[gi]),
        .i_phase_dir   (i_phase_dir[gi]),
        .i_sync_sel    (i_sync_sel[2*gi +: 2]),
        .i_sync_cmp    (i_sync_cmp[gi*WIDTH +: WIDTH]),
        .i_sync_in     (sync_in[gi]),
        .o_counter     (o_counter[gi*WIDTH +: WIDTH]),
        .o_counter_next(o_counter_next[gi*WIDTH +: WIDTH]),
        .o_dir         (o_dir[gi]),
        .o_zero        (o_zero[gi]),
        .o_prd         (o_prd[gi]),
        .o_sync        (o_sync[gi])
      );
    end
  endgenerate

endmodule
